banked_register_file_mp: RTL and testbench
==========================================

# banked_register_file_mp

Parametrised multi-port banked register file: the successor to the fixed 4-bank, 16-bit, four-read/two-write register file in the execute stage. It adds:

- configurable data width, depth, bank count and read-port count;
- same-cycle write-to-read bypass;
- defined write-port priority;
- a background bank-clear engine that zeroes one bank, one register per cycle, with a busy/done handshake.

It sits between decode (addresses, immediates, bank select) and the ALUs (operands), with writeback driving the write ports.

## Interface
Parameters:
- DATA_WIDTH, 16, register and immediate width
- REGS_PER_BANK, 32, registers per bank; power of two, ≥2; REG_W = log2(REGS_PER_BANK)
- NUM_BANKS, 4, bank count; power of two, ≥2; BANK_W = log2(NUM_BANKS)
- NUM_READ_PORTS, 4, independent read ports, ≥1

Ports:
- clock_i  in  1  clock; all state changes on rising edge
- reset_i  in  1  asynchronous, active-high reset
- bankSelect_i  in  BANK_W  bank used by all read and write ports this cycle
- writeEnableA_i / writeEnableB_i  in  1  write enables
- writeAddrA_i / writeAddrB_i  in  REG_W  register index within selected bank
- writeDataA_i / writeDataB_i  in  DATA_WIDTH  write data
- readEnable_i  in  NUM_READ_PORTS  per-port enable; bit p is port p
- readAddr_i  in  NUM_READ_PORTS*REG_W  flattened; port p at [p*REG_W +: REG_W]
- readImm_i  in  NUM_READ_PORTS*DATA_WIDTH  flattened immediates, same packing
- readData_o  out  NUM_READ_PORTS*DATA_WIDTH  flattened registered operands
- clearStart_i  in  1  single-cycle request to zero bank clearBank_i
- clearBank_i  in  BANK_W  bank to clear; sampled with clearStart_i
- clearBusy_o  out  1  high while the clear engine walks a bank
- clearDone_o  out  1  one-cycle pulse after the last register is cleared

## Operation
- Storage: NUM_BANKS*REGS_PER_BANK registers. Physical index = {bank, addr}; no arithmetic overflow is possible.
- Reads, per port p:
  - enable high: output = physical register {bankSelect_i, addr_p};
  - enable low: output = readImm_i slice p.
- Bypass: if an enabled read matches a write's physical index in the same cycle, the read returns the write data. Port B takes precedence over port A. This is a same-cycle match, not a hit on the prior cycle's write.
- Writes: A and B commit on the edge. If both target the same index, B wins.
- Clear engine FSM:
  - IDLE: on clearStart_i, latch clearBank_i, set ptr=0 and go to CLEAR.
  - CLEAR: each cycle zero register {clrBank, ptr} and increment ptr. At ptr=REGS_PER_BANK-1, zero that register and go to DONE.
  - DONE: clearDone_o=1 for one cycle, then return to IDLE.
- clearStart_i is ignored in CLEAR and DONE. A new request in the same cycle clearDone_o is high is also ignored; the earliest accepted restart is the cycle after DONE.
- Collisions with the clear engine:
  - A user write to the register the engine zeroes this cycle wins; the user data is stored.
  - A user write to an already-cleared register persists.
  - A user write to a not-yet-cleared register is overwritten when the pointer reaches it.
  - Reads return current array contents, plus bypass of user writes only. The clear engine is never bypassed: a read of the register being zeroed this cycle returns the pre-clear value.
- Writes and reads to banks other than clrBank are unaffected by the clear engine.

## Timing
- Read latency is 1 cycle: inputs at edge N give readData_o valid after edge N.
- Write visible to a non-bypassed read issued at the next edge.
- Clear of R registers: clearBusy_o high from the edge after the clearStart_i edge for exactly REGS_PER_BANK cycles. clearDone_o is high in the following cycle, total REGS_PER_BANK+1 cycles from start to done.
- Reset (asynchronous, immediate, mid-operation included):
  - all registers = 0 and readData_o = 0;
  - FSM = IDLE, ptr = 0, clearBusy_o = 0, clearDone_o = 0;
  - any in-progress clear is abandoned.
- First valid sampling is at the first rising edge after reset_i deasserts.

## Test plan
- Reset, then read all 4 ports of bank 0 at addrs 0,1,2,31 -> all readData_o slices 0x0000 one cycle later. Assert reset mid-clear at ptr=10 -> clearBusy_o=0 immediately and all registers read 0.
- Bank 2: write A addr5=0x1234; next cycle read port0 bank2 addr5 -> 0x1234. Read bank1 addr5 -> 0x0000.
- Bypass and priority:
  - Same cycle: A writes addr7=0xAAAA, B writes addr7=0x5555, port1 reads addr7 -> port1=0x5555 next cycle.
  - Following read of addr7 -> 0x5555.
- Immediates: readEnable_i=0b0101, readImm_i port1=0xBEEF, port3=0x00FF -> port1=0xBEEF and port3=0x00FF, ports 0/2 show register data.
- Clear of bank 3 pre-filled with nonzero values:
  - clearStart_i pulse -> clearBusy_o high for 32 cycles and clearDone_o pulse on cycle 33; all bank-3 registers then 0 and bank 0 untouched.
  - Second clearStart_i issued mid-clear is ignored.
- Clear collisions, bank 1:
  - Write addr20=0x9999 at ptr=5 -> addr20 reads 0 after done.
  - Write addr3=0x7777 at ptr=10 -> persists.
  - Write at the current ptr register -> user data persists.

Source files
------------

// File: rtl/banked_register_file_mp.sv
// Multi-port banked register file with same-cycle write bypass
// and a background bank-clear engine (one register per cycle).
module banked_register_file_mp #(
  parameter int DATA_WIDTH     = 16,
  parameter int REGS_PER_BANK  = 32,
  parameter int NUM_BANKS      = 4,
  parameter int NUM_READ_PORTS = 4,
  localparam int REG_W  = $clog2(REGS_PER_BANK),
  localparam int BANK_W = $clog2(NUM_BANKS)
) (
  input  logic                               clock_i,
  input  logic                               reset_i,
  input  logic [BANK_W-1:0]                  bankSelect_i,
  input  logic                               writeEnableA_i,
  input  logic [REG_W-1:0]                   writeAddrA_i,
  input  logic [DATA_WIDTH-1:0]              writeDataA_i,
  input  logic                               writeEnableB_i,
  input  logic [REG_W-1:0]                   writeAddrB_i,
  input  logic [DATA_WIDTH-1:0]              writeDataB_i,
  input  logic [NUM_READ_PORTS-1:0]          readEnable_i,
  input  logic [NUM_READ_PORTS*REG_W-1:0]    readAddr_i,
  input  logic [NUM_READ_PORTS*DATA_WIDTH-1:0] readImm_i,
  output logic [NUM_READ_PORTS*DATA_WIDTH-1:0] readData_o,
  input  logic                               clearStart_i,
  input  logic [BANK_W-1:0]                  clearBank_i,
  output logic                               clearBusy_o,
  output logic                               clearDone_o
);

  localparam int IDX_W    = BANK_W + REG_W;
  localparam int NUM_REGS = NUM_BANKS * REGS_PER_BANK;
  localparam logic [REG_W-1:0] LAST_PTR =
    REG_W'(REGS_PER_BANK - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_DONE
  } clr_state_t;

  clr_state_t state_q;
  clr_state_t state_d;
  logic [REG_W-1:0]  ptr_q;
  logic [REG_W-1:0]  ptr_d;
  logic [BANK_W-1:0] clr_bank_q;
  logic [BANK_W-1:0] clr_bank_d;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  logic             clr_we;
  logic [IDX_W-1:0] clr_idx;
  logic [IDX_W-1:0] idx_a;
  logic [IDX_W-1:0] idx_b;

  assign clr_we  = (state_q == ST_CLEAR);
  assign clr_idx = {clr_bank_q, ptr_q};
  assign idx_a   = {bankSelect_i, writeAddrA_i};
  assign idx_b   = {bankSelect_i, writeAddrB_i};

  assign clearBusy_o = (state_q == ST_CLEAR);
  assign clearDone_o = (state_q == ST_DONE);

  // Clear engine state, pointer and latched target bank.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      clr_bank_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      clr_bank_q <= clr_bank_d;
    end
  end

  // Clear engine next state: walk every register then pulse done.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    clr_bank_d = clr_bank_q;
    unique case (state_q)
      ST_IDLE: begin
        if (clearStart_i) begin
          state_d    = ST_CLEAR;
          ptr_d      = '0;
          clr_bank_d = clearBank_i;
        end
      end
      ST_CLEAR: begin
        if (ptr_q == LAST_PTR) begin
          state_d = ST_DONE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + REG_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  // Array update: clear first, user writes override, B over A.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      if (clr_we) begin
        regs_q[clr_idx] <= '0;
      end
      if (writeEnableA_i) begin
        regs_q[idx_a] <= writeDataA_i;
      end
      if (writeEnableB_i) begin
        regs_q[idx_b] <= writeDataB_i;
      end
    end
  end

  for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_rd
    logic [REG_W-1:0]      addr;
    logic [DATA_WIDTH-1:0] imm;
    logic [DATA_WIDTH-1:0] val;
    logic [DATA_WIDTH-1:0] rd_q;

    assign addr = readAddr_i[p*REG_W +: REG_W];
    assign imm  = readImm_i[p*DATA_WIDTH +: DATA_WIDTH];

    // Operand select: immediate, bypassed write data, or array.
    always_comb begin
      val = imm;
      if (readEnable_i[p]) begin
        if (writeEnableB_i && writeAddrB_i == addr) begin
          val = writeDataB_i;
        end else if (writeEnableA_i && writeAddrA_i == addr) begin
          val = writeDataA_i;
        end else begin
          val = regs_q[{bankSelect_i, addr}];
        end
      end
    end

    // Registered operand output.
    always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
        rd_q <= '0;
      end else begin
        rd_q <= val;
      end
    end

    assign readData_o[p*DATA_WIDTH +: DATA_WIDTH] = rd_q;
  end

endmodule

// File: tb/tb_banked_register_file_mp.sv
// Randomised and directed bench for banked_register_file_mp
// against a flat-array reference model.
module tb_banked_register_file_mp;

  localparam int DW = 16;
  localparam int R  = 32;
  localparam int NB = 4;
  localparam int NP = 4;
  localparam int RW = 5;
  localparam int BW = 2;

  logic              clock_i = 1'b0;
  logic              reset_i;
  logic [BW-1:0]     bsel;
  logic              we_a, we_b;
  logic [RW-1:0]     wa_a, wa_b;
  logic [DW-1:0]     wd_a, wd_b;
  logic [NP-1:0]     ren;
  logic [NP*RW-1:0]  raddr;
  logic [NP*DW-1:0]  rimm;
  logic [NP*DW-1:0]  rdata;
  logic              cs;
  logic [BW-1:0]     cb;
  logic              busy, done;

  banked_register_file_mp #(
    .DATA_WIDTH(DW), .REGS_PER_BANK(R),
    .NUM_BANKS(NB), .NUM_READ_PORTS(NP)
  ) dut (
    .clock_i(clock_i), .reset_i(reset_i),
    .bankSelect_i(bsel),
    .writeEnableA_i(we_a), .writeAddrA_i(wa_a),
    .writeDataA_i(wd_a),
    .writeEnableB_i(we_b), .writeAddrB_i(wa_b),
    .writeDataB_i(wd_b),
    .readEnable_i(ren), .readAddr_i(raddr),
    .readImm_i(rimm), .readData_o(rdata),
    .clearStart_i(cs), .clearBank_i(cb),
    .clearBusy_o(busy), .clearDone_o(done)
  );

  always #5 clock_i = ~clock_i;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] mem [NB*R];
  int clr_k;
  int clr_b;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NB*R; i++) mem[i] = '0;
    clr_k = -1;
    clr_b = 0;
  endtask

  task automatic idle_in();
    we_a = 0; we_b = 0; wa_a = '0; wa_b = '0;
    wd_a = '0; wd_b = '0; ren = '0; raddr = '0;
    rimm = '0; cs = 0; cb = '0;
  endtask

  task automatic set_rd(input int p, input int a);
    ren[p] = 1'b1;
    raddr[p*RW +: RW] = RW'(a);
  endtask

  task automatic tick();
    logic [DW-1:0] er [NP];
    logic [RW-1:0] ra;
    int k;
    for (int p = 0; p < NP; p++) begin
      ra = raddr[p*RW +: RW];
      if (!ren[p]) er[p] = rimm[p*DW +: DW];
      else if (we_b && wa_b == ra) er[p] = wd_b;
      else if (we_a && wa_a == ra) er[p] = wd_a;
      else er[p] = mem[bsel*R + ra];
    end
    @(posedge clock_i);
    if (clr_k >= 0) begin
      k = clr_k + 1;
      if (k >= 1 && k <= R) mem[clr_b*R + k - 1] = '0;
      clr_k = (k == R + 1) ? -1 : k;
    end else if (cs) begin
      clr_k = 0;
      clr_b = cb;
    end
    if (we_a) mem[bsel*R + wa_a] = wd_a;
    if (we_b) mem[bsel*R + wa_b] = wd_b;
    #1;
    for (int p = 0; p < NP; p++)
      check($sformatf("rd%0d", p), rdata[p*DW +: DW], er[p]);
    check("busy", busy, clr_k >= 0 && clr_k < R);
    check("done", done, clr_k == R);
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    #2;
    model_reset();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rdata", rdata, 0);
    @(negedge clock_i);
    reset_i = 1'b0;
  endtask

  task automatic fill(input int b);
    for (int a = 0; a < R; a += 2) begin
      idle_in();
      bsel = BW'(b);
      we_a = 1; wa_a = RW'(a);
      wd_a = DW'($urandom) | 16'h1;
      we_b = 1; wa_b = RW'(a + 1);
      wd_b = DW'($urandom) | 16'h1;
      tick();
    end
  endtask

  task automatic rd_bank(input int b, input bit zero);
    for (int a = 0; a < R; a += NP) begin
      idle_in();
      bsel = BW'(b);
      for (int p = 0; p < NP; p++) set_rd(p, a + p);
      tick();
      if (zero) check("bank_zero", rdata, 0);
    end
  endtask

  int busy_cnt;
  int done_at;
  int guard;

  initial begin
    model_reset();
    idle_in();
    bsel = '0;
    reset_i = 1'b1;
    #12;
    check("init_rdata", rdata, 0);
    check("init_busy", busy, 0);
    @(negedge clock_i);
    reset_i = 1'b0;

    idle_in(); bsel = 0;
    set_rd(0, 0); set_rd(1, 1); set_rd(2, 2); set_rd(3, 31);
    tick();
    check("plan_zero_rd", rdata, 0);

    idle_in(); bsel = 2;
    we_a = 1; wa_a = 5; wd_a = 16'h1234;
    tick();
    idle_in(); bsel = 2; set_rd(0, 5);
    tick();
    check("plan_b2a5", rdata[15:0], 16'h1234);
    idle_in(); bsel = 1; set_rd(0, 5);
    tick();
    check("plan_b1a5", rdata[15:0], 16'h0000);

    idle_in(); bsel = 2;
    we_a = 1; wa_a = 7; wd_a = 16'hAAAA;
    we_b = 1; wa_b = 7; wd_b = 16'h5555;
    set_rd(1, 7);
    tick();
    check("plan_bypass_b", rdata[31:16], 16'h5555);
    idle_in(); bsel = 2; set_rd(1, 7);
    tick();
    check("plan_prio_b", rdata[31:16], 16'h5555);

    idle_in(); bsel = 2;
    set_rd(0, 5); set_rd(2, 7);
    ren = 4'b0101;
    rimm[31:16] = 16'hBEEF;
    rimm[63:48] = 16'h00FF;
    tick();
    check("plan_imm1", rdata[31:16], 16'hBEEF);
    check("plan_imm3", rdata[63:48], 16'h00FF);
    check("plan_reg0", rdata[15:0], 16'h1234);
    check("plan_reg2", rdata[47:32], 16'h5555);

    fill(3);
    fill(0);
    idle_in(); cs = 1; cb = 3;
    tick();
    busy_cnt = busy ? 1 : 0;
    done_at = 0;
    for (int c = 1; c <= 40; c++) begin
      idle_in();
      if (c == 10) begin cs = 1; cb = 0; end
      if (c == 33) begin cs = 1; cb = 0; end
      tick();
      if (busy) busy_cnt++;
      if (done && done_at == 0) done_at = c;
    end
    check("clr_busy_cycles", busy_cnt, 32);
    check("clr_done_cycle", done_at, 32);
    rd_bank(3, 1);
    rd_bank(0, 0);

    fill(1);
    idle_in(); cs = 1; cb = 1;
    tick();
    for (int c = 1; c <= 40; c++) begin
      idle_in(); bsel = 1;
      if (clr_k == 5) begin
        we_a = 1; wa_a = 20; wd_a = 16'h9999;
      end
      if (clr_k == 10) begin
        we_a = 1; wa_a = 3; wd_a = 16'h7777;
      end
      if (clr_k == 12) begin
        we_b = 1; wa_b = 12; wd_b = 16'h4242;
      end
      if (clr_k == 13) set_rd(1, 13);
      tick();
      if (ren[1]) check("pre_clear_nz", rdata[31:16] != 0, 1);
    end
    idle_in(); bsel = 1;
    set_rd(0, 20); set_rd(1, 3); set_rd(2, 12);
    tick();
    check("col_a20", rdata[15:0], 16'h0000);
    check("col_a3", rdata[31:16], 16'h7777);
    check("col_ptr", rdata[47:32], 16'h4242);

    idle_in(); cs = 1; cb = 2;
    tick();
    guard = 0;
    while (clr_k != 10 && guard < 40) begin
      idle_in();
      tick();
      guard++;
    end
    check("reach_ptr10", clr_k, 10);
    do_reset();
    idle_in(); bsel = 2;
    set_rd(0, 5); set_rd(1, 7);
    tick();
    check("rst_b2_regs", rdata[31:0], 0);
    rd_bank(1, 1);

    for (int i = 0; i < 400; i++) begin
      idle_in();
      bsel = BW'($urandom);
      we_a = 1'($urandom); wa_a = RW'($urandom % 8);
      wd_a = DW'($urandom);
      we_b = 1'($urandom); wa_b = RW'($urandom % 8);
      wd_b = DW'($urandom);
      ren = NP'($urandom);
      for (int p = 0; p < NP; p++)
        raddr[p*RW +: RW] = RW'($urandom % 8);
      rimm = {$urandom, $urandom};
      cs = ($urandom % 16) == 0;
      cb = BW'($urandom);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
